// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW hazard bubbles and ALU operand delivery.
// Build option OPERAND_FWD_EN selects EX/MEM + MEM/WB forwarding; otherwise hazards are resolved by stalling.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alufn,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic              mwb_reg_write,
    input  logic [XLEN-1:0]   mwb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [4:0]        ex_shamt,
    output logic [3:0]        ex_alufn,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);
    typedef enum logic {S_RUN = 1'b0, S_STALL = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic              hazard;
    logic [1:0]        bubbles;
    logic              load_bubble, load_id;
    logic              ex_rs1_used, ex_rs2_used, ex_alu_src;
    logic [REG_AW-1:0] ex_rs1_addr, ex_rs2_addr;
    logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data, ex_imm;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

    // A write to x0 can never match because src must be non-zero.
    function automatic logic src_match(input logic [REG_AW-1:0] dst, input logic wen,
                                       input logic [REG_AW-1:0] src, input logic used);
        return wen && used && (src != '0) && (dst == src);
    endfunction

`ifdef OPERAND_FWD_EN
    always_comb begin
        hazard  = id_valid && ex_valid && ex_mem_read &&
                  (src_match(ex_rd_addr, ex_reg_write, id_rs1_addr, id_rs1_used) ||
                   src_match(ex_rd_addr, ex_reg_write, id_rs2_addr, id_rs2_used));
        bubbles = 2'd1;
    end

    // EX/MEM is younger than MEM/WB so it wins; a load in EX/MEM has no data yet.
    always_comb begin
        fwd_rs1 = ex_rs1_data;
        fwd_rs2 = ex_rs2_data;
        if (src_match(exm_rd_addr, exm_reg_write && !exm_mem_read, ex_rs1_addr, ex_rs1_used))
            fwd_rs1 = exm_result;
        else if (src_match(mwb_rd_addr, mwb_reg_write, ex_rs1_addr, ex_rs1_used))
            fwd_rs1 = mwb_data;
        if (src_match(exm_rd_addr, exm_reg_write && !exm_mem_read, ex_rs2_addr, ex_rs2_used))
            fwd_rs2 = exm_result;
        else if (src_match(mwb_rd_addr, mwb_reg_write, ex_rs2_addr, ex_rs2_used))
            fwd_rs2 = mwb_data;
    end
`else
    logic ex_hit, exm_hit;
    logic unused_fwd;

    always_comb begin
        ex_hit  = ex_valid &&
                  (src_match(ex_rd_addr, ex_reg_write, id_rs1_addr, id_rs1_used) ||
                   src_match(ex_rd_addr, ex_reg_write, id_rs2_addr, id_rs2_used));
        exm_hit = src_match(exm_rd_addr, exm_reg_write, id_rs1_addr, id_rs1_used) ||
                  src_match(exm_rd_addr, exm_reg_write, id_rs2_addr, id_rs2_used);
        hazard  = id_valid && (ex_hit || exm_hit);
        bubbles = ex_hit ? 2'd2 : 2'd1;
    end

    // MEM/WB is covered by the write-through regfile, so operands come straight from it.
    assign fwd_rs1    = ex_rs1_data;
    assign fwd_rs2    = ex_rs2_data;
    assign unused_fwd = ^{exm_mem_read, exm_result, mwb_rd_addr, mwb_reg_write, mwb_data,
                          ex_rs1_addr, ex_rs2_addr, ex_rs1_used, ex_rs2_used};
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_bubble = 1'b0;
        load_id     = 1'b0;
        if (flush) begin
            state_nxt   = S_RUN;
            cnt_nxt     = 2'd0;
            load_bubble = 1'b1;
        end else if (ex_hold) begin
            state_nxt = state;
        end else if (state == S_STALL) begin
            load_bubble = 1'b1;
            cnt_nxt     = cnt - 2'd1;
            if (cnt <= 2'd1) state_nxt = S_RUN;
        end else if (hazard) begin
            // The first bubble goes in now; STALL only covers the remaining ones.
            load_bubble = 1'b1;
            cnt_nxt     = bubbles - 2'd1;
            if (bubbles > 2'd1) state_nxt = S_STALL;
        end else begin
            load_id = 1'b1;
        end
    end

    assign id_ready = ~rst & (flush | (~ex_hold & (state == S_RUN) & ~hazard));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RUN;
            cnt          <= 2'd0;
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rs1_used  <= 1'b0;
            ex_rs2_used  <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_alu_src   <= 1'b0;
            ex_alufn     <= 4'd0;
            ex_rd_addr   <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_bubble) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
            end else if (load_id) begin
                ex_valid     <= id_valid;
                ex_pc        <= id_pc;
                ex_rs1_addr  <= id_rs1_addr;
                ex_rs2_addr  <= id_rs2_addr;
                ex_rs1_used  <= id_rs1_used;
                ex_rs2_used  <= id_rs2_used;
                ex_rs1_data  <= id_rs1_data;
                ex_rs2_data  <= id_rs2_data;
                ex_imm       <= id_imm;
                ex_alu_src   <= id_alu_src;
                ex_alufn     <= id_alufn;
                ex_rd_addr   <= id_rd_addr;
                ex_reg_write <= id_valid & id_reg_write;
                ex_mem_read  <= id_valid & id_mem_read;
                ex_mem_write <= id_valid & id_mem_write;
            end
        end
    end

    assign ex_a          = fwd_rs1;
    assign ex_b          = ex_alu_src ? ex_imm : fwd_rs2;
    assign ex_shamt      = ex_b[4:0];
    assign ex_store_data = fwd_rs2;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage with a small EX/MEM -> MEM/WB environment model.
// Expectations adapt to whether OPERAND_FWD_EN is defined for the build.
module tb_id_ex_operand_stage;
`ifdef OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [31:0] ALU_TAG  = 32'h0BAD_0000;
    localparam logic [31:0] LOAD_TAG = 32'h0000_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used, id_alu_src;
    logic [3:0]  id_alufn;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush, ex_hold;
    logic [4:0]  exm_rd_addr, mwb_rd_addr;
    logic        exm_reg_write, exm_mem_read, mwb_reg_write;
    logic [31:0] exm_result, mwb_data;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_pc, ex_store_data;
    logic [4:0]  ex_shamt, ex_rd_addr;
    logic [3:0]  ex_alufn;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alufn(id_alufn), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_hold(ex_hold),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
        .exm_result(exm_result), .mwb_rd_addr(mwb_rd_addr), .mwb_reg_write(mwb_reg_write),
        .mwb_data(mwb_data), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_shamt(ex_shamt), .ex_alufn(ex_alufn), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, a, b, store;
        logic [3:0]  fn;
        logic [4:0]  rd;
        logic [2:0]  ctl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock edge; downstream stages advance from what EX held, then EX output is scored.
    task automatic tick();
        logic hv, rv, ev, erw, emr, xrw, xmr;
        logic [4:0] erd, xrd;
        logic [31:0] epc, xres;
        exp_t e;
        hv = ex_hold; rv = rst; ev = ex_valid; erw = ex_reg_write; emr = ex_mem_read;
        erd = ex_rd_addr; epc = ex_pc;
        xrw = exm_reg_write; xmr = exm_mem_read; xrd = exm_rd_addr; xres = exm_result;
        @(posedge clk);
        #1;
        if (rv) begin
            exm_rd_addr = '0; exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_result = '0;
            mwb_rd_addr = '0; mwb_reg_write = 1'b0; mwb_data = '0;
        end else begin
            mwb_rd_addr   = xrd;
            mwb_reg_write = xrw & ~hv;
            mwb_data      = xmr ? (xres ^ LOAD_TAG) : xres;
            if (!hv) begin
                exm_rd_addr   = ev ? erd : 5'd0;
                exm_reg_write = ev & erw;
                exm_mem_read  = ev & emr;
                exm_result    = epc ^ ALU_TAG;
            end
        end
        #1;
        if (ex_valid && !hv && !rv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ex_valid", 32'(ex_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ex_pc", ex_pc, e.pc);
                check("ex_a", ex_a, e.a);
                check("ex_b", ex_b, e.b);
                check("ex_shamt", 32'(ex_shamt), 32'(e.b[4:0]));
                check("ex_store_data", ex_store_data, e.store);
                check("ex_alufn", 32'(ex_alufn), 32'(e.fn));
                check("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
                check("ex_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'(e.ctl));
            end
        end
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [31:0] d1, input logic [4:0] rs2, input logic u2,
                         input logic [31:0] d2, input logic src, input logic [31:0] imm,
                         input logic [3:0] fn, input logic [4:0] rd, input logic [2:0] ctl);
        id_valid = 1'b1; id_pc = pc;
        id_rs1_addr = rs1; id_rs1_used = u1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_used = u2; id_rs2_data = d2;
        id_alu_src = src; id_imm = imm; id_alufn = fn; id_rd_addr = rd;
        {id_reg_write, id_mem_read, id_mem_write} = ctl;
        #1;
    endtask

    // Present one instruction, count bubbles until accepted, and queue its expected EX view.
    task automatic issue(input string tag, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic u1, input logic [31:0] d1, input logic [4:0] rs2,
                         input logic u2, input logic [31:0] d2, input logic src,
                         input logic [31:0] imm, input logic [3:0] fn, input logic [4:0] rd,
                         input logic [2:0] ctl, input logic [31:0] exp_a,
                         input logic [31:0] exp_store, input int exp_bub);
        int   bub;
        exp_t e;
        bub = 0;
        drive(pc, rs1, u1, d1, rs2, u2, d2, src, imm, fn, rd, ctl);
        while (!id_ready && bub < 8) begin
            bub++;
            tick();
        end
        if (!id_ready) begin
            check({tag, "_accept_timeout"}, 32'(id_ready), 32'd1);
        end else begin
            e.pc = pc; e.a = exp_a; e.b = src ? imm : exp_store; e.store = exp_store;
            e.fn = fn; e.rd = rd; e.ctl = ctl;
            exp_q.push_back(e);
            tick();
        end
        id_valid = 1'b0;
        check({tag, "_bubbles"}, 32'(bub), 32'(exp_bub));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
        check({tag, "_ex_a"}, ex_a, 32'd0);
        check({tag, "_ex_b"}, ex_b, 32'd0);
        check({tag, "_ex_pc"}, ex_pc, 32'd0);
        check({tag, "_ex_store"}, ex_store_data, 32'd0);
        check({tag, "_ex_misc"}, 32'({ex_shamt, ex_alufn, ex_rd_addr}), 32'd0);
        check({tag, "_ex_ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
        check({tag, "_id_ready"}, 32'(id_ready), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1, r2, r3;
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_alu_src = 1'b0; id_alufn = '0; id_rd_addr = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        exm_rd_addr = '0; exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_result = '0;
        mwb_rd_addr = '0; mwb_reg_write = 1'b0; mwb_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_reset("reset");

        r1 = $urandom(); r2 = $urandom(); r3 = 32'($urandom_range(1000, 1));
        issue("t1", 32'h100, 5'd1, 1'b1, r1, 5'd2, 1'b1, r2, 1'b0, 32'h5, 4'h0, 5'd7,
              3'b100, r1, r2, 0);
        issue("t2", 32'h104, 5'd9, 1'b1, r3, 5'd19, 1'b0, 32'hDEAD, 1'b1, 32'hFFFF_FFF3,
              4'h5, 5'd8, 3'b100, r3, 32'hDEAD, 0);
        idle(3);

        // RAW on an ALU result one instruction back.
        issue("t3p", 32'h200, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h6, 1'b0, 32'h0, 4'h0, 5'd5,
              3'b100, 32'h1, 32'h6, 0);
        issue("t3c", 32'h204, 5'd5, 1'b1, 32'h55, 5'd3, 1'b1, 32'h33, 1'b0, 32'h0, 4'h8, 5'd6,
              3'b100, FWD ? (32'h200 ^ ALU_TAG) : 32'h55, 32'h33, FWD ? 0 : 2);
        idle(3);

        // Load-use.
        issue("t4l", 32'h300, 5'd1, 1'b1, 32'h1000, 5'd0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 5'd5,
              3'b110, 32'h1000, 32'h0, 0);
        issue("t4u", 32'h304, 5'd5, 1'b1, 32'h66, 5'd5, 1'b1, 32'h66, 1'b0, 32'h0, 4'h0, 5'd6,
              3'b100, FWD ? (32'h300 ^ ALU_TAG ^ LOAD_TAG) : 32'h66,
              FWD ? (32'h300 ^ ALU_TAG ^ LOAD_TAG) : 32'h66, FWD ? 1 : 2);
        idle(3);

        // EX/MEM and MEM/WB both hold x5.
        issue("t5a", 32'h400, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, 1'b0, 32'h0, 4'h0, 5'd5,
              3'b100, 32'h1, 32'h2, 0);
        issue("t5b", 32'h404, 5'd1, 1'b1, 32'h3, 5'd2, 1'b1, 32'h4, 1'b0, 32'h0, 4'h0, 5'd5,
              3'b100, 32'h3, 32'h4, 0);
        issue("t5c", 32'h408, 5'd5, 1'b1, 32'h77, 5'd4, 1'b1, 32'h44, 1'b0, 32'h0, 4'h2, 5'd9,
              3'b100, FWD ? (32'h404 ^ ALU_TAG) : 32'h77, 32'h44, FWD ? 0 : 2);
        idle(3);

        // x0 destination followed by x0 reads.
        issue("t6a", 32'h500, 5'd1, 1'b1, 32'h9, 5'd2, 1'b1, 32'h8, 1'b1, 32'h1234, 4'h0, 5'd0,
              3'b100, 32'h9, 32'h8, 0);
        issue("t6b", 32'h504, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 5'd10,
              3'b100, 32'h0, 32'h0, 0);
        idle(3);

        // Store data hazard two instructions back.
        issue("t8p", 32'h600, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, 1'b0, 32'h0, 4'h0, 5'd5,
              3'b100, 32'h1, 32'h2, 0);
        issue("t8i", 32'h604, 5'd1, 1'b1, 32'h3, 5'd2, 1'b1, 32'h4, 1'b0, 32'h0, 4'h0, 5'd6,
              3'b100, 32'h3, 32'h4, 0);
        issue("t8s", 32'h608, 5'd1, 1'b1, 32'h10, 5'd5, 1'b1, 32'h88, 1'b1, 32'h8, 4'h0, 5'd0,
              3'b001, 32'h10, FWD ? (32'h600 ^ ALU_TAG) : 32'h88, FWD ? 0 : 1);
        idle(3);

        // Downstream hold freezes EX for three cycles.
        issue("t9q", 32'h700, 5'd1, 1'b1, 32'h11, 5'd2, 1'b1, 32'h22, 1'b0, 32'h0, 4'h1, 5'd7,
              3'b100, 32'h11, 32'h22, 0);
        ex_hold = 1'b1;
        drive(32'h704, 5'd1, 1'b1, 32'h12, 5'd2, 1'b1, 32'h23, 1'b0, 32'h0, 4'h1, 5'd8, 3'b100);
        check("t9_hold_ready", 32'(id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t9_hold_valid", 32'(ex_valid), 32'd1);
            check("t9_hold_pc", ex_pc, 32'h700);
            check("t9_hold_ready", 32'(id_ready), 32'd0);
        end
        ex_hold = 1'b0;
        issue("t9r", 32'h704, 5'd1, 1'b1, 32'h12, 5'd2, 1'b1, 32'h23, 1'b0, 32'h0, 4'h1, 5'd8,
              3'b100, 32'h12, 32'h23, 0);
        idle(3);

        // Flush during a load-use stall.
        issue("t10l", 32'h800, 5'd1, 1'b1, 32'h2000, 5'd0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 5'd5,
              3'b110, 32'h2000, 32'h0, 0);
        drive(32'h804, 5'd5, 1'b1, 32'h1, 5'd3, 1'b1, 32'h3, 1'b0, 32'h0, 4'h0, 5'd6, 3'b100);
        check("t10_hazard_ready", 32'(id_ready), 32'd0);
        tick();
        flush = 1'b1;
        #1;
        check("t10_flush_ready", 32'(id_ready), 32'd1);
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        check("t10_flush_valid", 32'(ex_valid), 32'd0);
        check("t10_flush_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
        issue("t10n", 32'h900, 5'd1, 1'b1, 32'hAB, 5'd2, 1'b1, 32'hCD, 1'b0, 32'h0, 4'h3, 5'd4,
              3'b100, 32'hAB, 32'hCD, 0);
        idle(2);

        // Reset held two cycles in the middle of a stall.
        issue("t11p", 32'hA00, 5'd1, 1'b1, 32'h3000, 5'd0, 1'b0, 32'h0, 1'b1, 32'h4, 4'h0, 5'd5,
              3'b110, 32'h3000, 32'h0, 0);
        drive(32'hA04, 5'd5, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, 1'b0, 32'h0, 4'h0, 5'd6, 3'b100);
        tick();
        rst = 1'b1;
        #1;
        check("t11_rst_ready", 32'(id_ready), 32'd0);
        tick(); tick();
        rst = 1'b0;
        id_valid = 1'b0;
        #1;
        check_reset("t11");
        issue("t11n", 32'hA08, 5'd5, 1'b1, 32'h5, 5'd2, 1'b1, 32'h6, 1'b0, 32'h0, 4'h0, 5'd7,
              3'b100, 32'h5, 32'h6, 0);
        idle(2);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
